// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversample tick generator with frame-boundary
// reconfiguration, frame tracking from the receiver's done flag, and a show-ahead byte FIFO.
module uart_rx_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 326,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        P_CLK,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_load,
  input  logic                        cfg_en,
  input  logic                        i_RX,
  output logic                        o_TICK,
  input  logic [7:0]                  i_RX_DATA,
  input  logic                        i_RX_DONE,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {OFF, RUN, PEND_CFG, PEND_OFF} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] pend_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic             pend_valid_reg;
  logic             tick_reg;

  logic             rx_meta_reg, rx_sync_reg, rx_sync_d_reg;
  logic             done_d_reg;
  logic             busy_reg;

  logic [7:0]       mem_reg [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overrun_reg;

  logic             rx_fall, done_rise;
  logic             fifo_full, fifo_pop, fifo_push, fifo_drop;
  logic [DIV_W-1:0] pend_now;
  logic [DIV_W-1:0] en_div;

  // Divisor 0 behaves as 1, so both reload to 0 and tick every cycle.
  function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  function automatic logic tick_of(input logic [DIV_W-1:0] d);
    return (d <= DIV_W'(1));
  endfunction

  assign rx_fall   = rx_sync_d_reg & ~rx_sync_reg;
  assign done_rise = i_RX_DONE & ~done_d_reg;
  assign pend_now  = cfg_load ? cfg_div : pend_reg;
  assign en_div    = cfg_load ? cfg_div : div_reg;

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      state_reg      <= OFF;
      div_reg        <= DIV_W'(DEFAULT_DIV);
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      cnt_reg        <= '0;
      tick_reg       <= 1'b0;
    end else begin
      // Running countdown; state arms below override it on (re)load or stop.
      if (cnt_reg == '0) begin
        cnt_reg  <= reload_of(div_reg);
        tick_reg <= tick_of(div_reg);
      end else begin
        cnt_reg  <= cnt_reg - DIV_W'(1);
        tick_reg <= (cnt_reg == DIV_W'(1));
      end
      if (cfg_load) pend_reg <= cfg_div;

      case (state_reg)
        OFF: begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          if (cfg_load) div_reg <= cfg_div;
          if (cfg_en) begin
            state_reg <= RUN;
            cnt_reg   <= reload_of(en_div);
            tick_reg  <= tick_of(en_div);
          end
        end
        RUN: begin
          if (cfg_load) pend_valid_reg <= 1'b1;
          if (!cfg_en)       state_reg <= PEND_OFF;
          else if (cfg_load) state_reg <= PEND_CFG;
        end
        PEND_CFG: begin
          if (!cfg_en) begin
            state_reg <= PEND_OFF;
          end else if (!busy_reg) begin
            state_reg      <= RUN;
            div_reg        <= pend_now;
            cnt_reg        <= reload_of(pend_now);
            tick_reg       <= tick_of(pend_now);
            pend_valid_reg <= 1'b0;
          end
        end
        PEND_OFF: begin
          if (cfg_load) pend_valid_reg <= 1'b1;
          if (cfg_en) begin
            state_reg <= (pend_valid_reg || cfg_load) ? PEND_CFG : RUN;
          end else if (!busy_reg) begin
            state_reg      <= OFF;
            cnt_reg        <= '0;
            tick_reg       <= 1'b0;
            pend_valid_reg <= 1'b0;
            if (pend_valid_reg || cfg_load) div_reg <= pend_now;
          end
        end
        default: state_reg <= OFF;
      endcase
    end
  end

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_sync_d_reg <= 1'b1;
      done_d_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      rx_meta_reg   <= i_RX;
      rx_sync_reg   <= rx_meta_reg;
      rx_sync_d_reg <= rx_sync_reg;
      done_d_reg    <= i_RX_DONE;
      if (done_rise)                          busy_reg <= 1'b0;
      else if (rx_fall && state_reg != OFF)   busy_reg <= 1'b1;
    end
  end

  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_pop  = (count_reg != '0) && rx_ready;
  assign fifo_push = done_rise && (!fifo_full || fifo_pop);
  assign fifo_drop = done_rise && fifo_full && !fifo_pop;

  always_ff @(posedge P_CLK) begin
    if (fifo_push) mem_reg[wr_ptr_reg] <= i_RX_DATA;
  end

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(fifo_push) - CW'(fifo_pop);
      if (fifo_drop)    overrun_reg <= 1'b1;
      else if (ovr_clr) overrun_reg <= 1'b0;
    end
  end

  assign o_TICK     = tick_reg;
  assign busy       = busy_reg;
  assign rx_valid   = (count_reg != '0);
  assign rx_data    = rx_valid ? mem_reg[rd_ptr_reg] : 8'h00;
  assign fifo_count = count_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: emulates the receiver around the controller and checks ticks,
// frame capture and FIFO behaviour against a queue-based reference.
module tb_uart_rx_ctrl;
  localparam int DIV_W   = 16;
  localparam int DEPTH   = 8;
  localparam int DEF_DIV = 326;

  logic             P_CLK = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_load = 1'b0;
  logic             cfg_en = 1'b0;
  logic             i_RX = 1'b1;
  logic             o_TICK;
  logic [7:0]       i_RX_DATA = 8'h00;
  logic             i_RX_DONE = 1'b0;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready = 1'b0;
  logic [3:0]       fifo_count;
  logic             overrun;
  logic             ovr_clr = 1'b0;
  logic             busy;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;
  int en_cyc = 0;
  int d_cyc = 0;
  bit tick_dead = 1'b0;
  int tick_q[$];
  logic [7:0] m_q[$];
  bit m_ovr = 1'b0;
  bit m_done_d = 1'b0;

  uart_rx_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .P_CLK(P_CLK), .reset(reset), .cfg_div(cfg_div), .cfg_load(cfg_load), .cfg_en(cfg_en),
    .i_RX(i_RX), .o_TICK(o_TICK), .i_RX_DATA(i_RX_DATA), .i_RX_DONE(i_RX_DONE),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 P_CLK = ~P_CLK;
  always @(posedge P_CLK) cyc++;
  always @(negedge P_CLK) if (o_TICK) tick_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge P_CLK);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int got = 0;
    int budget = 0;
    if (tick_dead) return;
    while (got < n && budget < 5000) begin
      step();
      budget++;
      if (o_TICK) got++;
    end
    if (got < n) begin
      tick_dead = 1'b1;
      check("tick_wait", got, n);
    end
  endtask

  // Disable, load the divisor while OFF, then enable; en_cyc is the enable cycle.
  task automatic start_div(input int d);
    cfg_en = 1'b0;
    repeat (4) step();
    cfg_div = DIV_W'(d);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    cfg_en = 1'b1;
    en_cyc = cyc;
    tick_q.delete();
  endtask

  task automatic check_ticks(input string tag, input int first, input int per, input int n);
    int budget = 0;
    int bad = 0;
    while (tick_q.size() < n && budget < 4000) begin
      step();
      budget++;
    end
    check({tag, "_first"}, (tick_q.size() > 0) ? tick_q[0] : -1, first);
    for (int i = 1; i < tick_q.size(); i++)
      if (tick_q[i] - tick_q[i-1] != per) bad++;
    check({tag, "_period"}, bad, 0);
    check({tag, "_count"}, tick_q.size() >= n, 1);
    $display("ticks %s: first at %0d, period %0d", tag, first, per);
  endtask

  // Start bit, 8 data bits LSB first, half a stop bit, then the done edge.
  task automatic send_frame(input logic [7:0] b);
    i_RX = 1'b0;
    wait_ticks(16);
    check("busy_mid", busy, 1);
    for (int i = 0; i < 8; i++) begin
      i_RX = b[i];
      wait_ticks(16);
    end
    i_RX = 1'b1;
    wait_ticks(8);
    i_RX_DATA = b;
    i_RX_DONE = 1'b1;
    d_cyc = cyc;
    check("pre_valid", rx_valid, 0);
    step();
    check("frame_valid", rx_valid, 1);
    check("frame_data", rx_data, b);
    check("busy_clr", busy, 0);
    i_RX_DONE = 1'b0;
    repeat (4) step();
    $display("frame %02h done edge at cycle %0d", b, d_cyc);
  endtask

  // Compares the DUT against the queue model for this cycle, then advances both.
  task automatic fifo_step();
    bit pop;
    bit push;
    check("fifo_valid", rx_valid, m_q.size() != 0);
    check("fifo_count", fifo_count, m_q.size());
    check("fifo_ovr", overrun, m_ovr);
    if (m_q.size() != 0) check("fifo_data", rx_data, m_q[0]);
    pop = (m_q.size() != 0) && rx_ready;
    push = i_RX_DONE && !m_done_d;
    m_done_d = i_RX_DONE;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < DEPTH) begin
      m_q.push_back(i_RX_DATA);
      $display("push %02h, %0d held", i_RX_DATA, m_q.size());
    end else if (push) begin
      m_ovr = 1'b1;
      $display("drop %02h, fifo full", i_RX_DATA);
    end else if (ovr_clr) begin
      m_ovr = 1'b0;
    end
    step();
  endtask

  task automatic pulse(input logic [7:0] b);
    i_RX_DATA = b;
    i_RX_DONE = 1'b1;
    fifo_step();
    i_RX_DONE = 1'b0;
    fifo_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_en = 1'b0;
    cfg_load = 1'b0;
    i_RX_DONE = 1'b0;
    rx_ready = 1'b0;
    ovr_clr = 1'b0;
    i_RX = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    m_q.delete();
    m_ovr = 1'b0;
    m_done_d = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int late;
    int bad;
    int first_new;
    int n_new;
    int prev;
    logic [7:0] b;

    repeat (3) step();
    check("rst_tick", o_TICK, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    start_div(4);
    check_ticks("div4", en_cyc + 4, 4, 6);
    start_div(0);
    check_ticks("div0", en_cyc + 1, 1, 6);
    start_div(1);
    check_ticks("div1", en_cyc + 1, 1, 6);
    for (int k = 0; k < 3; k++) begin
      int d;
      d = $urandom_range(2, 9);
      start_div(d);
      check_ticks($sformatf("div%0d", d), en_cyc + d, d, 5);
    end

    start_div(4);
    rx_ready = 1'b1;
    send_frame(8'hA5);
    send_frame(8'h3C);
    check("frames_ovr", overrun, 0);

    // Divisor change mid-frame: old period until the done edge, new one after.
    b = 8'($urandom);
    tick_q.delete();
    fork
      send_frame(b);
      begin
        repeat (150) step();
        cfg_div = 16'd8;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
      end
    join
    repeat (60) step();
    bad = 0;
    first_new = -1;
    n_new = 0;
    prev = -1;
    for (int i = 0; i < tick_q.size(); i++) begin
      if (tick_q[i] <= d_cyc + 1) begin
        if (i > 0 && tick_q[i] - tick_q[i-1] != 4) bad++;
      end else begin
        if (first_new < 0) first_new = tick_q[i];
        else if (tick_q[i] - prev != 8) bad++;
        prev = tick_q[i];
        n_new++;
      end
    end
    check("reload_periods", bad, 0);
    check("reload_first", first_new, d_cyc + 9);
    check("reload_count", n_new >= 5, 1);

    // Disable mid-frame: frame completes, then ticks stop.
    b = 8'($urandom);
    tick_q.delete();
    fork
      send_frame(b);
      begin
        repeat (300) step();
        cfg_en = 1'b0;
      end
    join
    repeat (40) step();
    late = 0;
    bad = 0;
    for (int i = 0; i < tick_q.size(); i++) begin
      if (tick_q[i] > d_cyc + 1) late++;
      if (i > 0 && tick_q[i] - tick_q[i-1] != 8) bad++;
    end
    check("off_late_ticks", late, 0);
    check("off_periods", bad, 0);
    check("off_tick", o_TICK, 0);
    i_RX = 1'b0;
    repeat (10) step();
    check("off_no_busy", busy, 0);
    i_RX = 1'b1;
    repeat (4) step();

    // FIFO: overrun, ordered drain, clear, full with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 9; i++) pulse(8'($urandom));
    check("full_count", fifo_count, 8);
    check("ovr_set", overrun, 1);
    rx_ready = 1'b1;
    repeat (8) fifo_step();
    rx_ready = 1'b0;
    fifo_step();
    check("drained", fifo_count, 0);
    check("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    fifo_step();
    ovr_clr = 1'b0;
    fifo_step();
    check("ovr_clr", overrun, 0);
    for (int i = 0; i < 8; i++) pulse(8'($urandom));
    rx_ready = 1'b1;
    i_RX_DATA = 8'($urandom);
    i_RX_DONE = 1'b1;
    fifo_step();
    rx_ready = 1'b0;
    i_RX_DONE = 1'b0;
    fifo_step();
    check("simul_count", fifo_count, 8);
    check("simul_ovr", overrun, 0);
    rx_ready = 1'b1;
    repeat (9) fifo_step();
    for (int i = 0; i < 400; i++) begin
      rx_ready = ($urandom_range(0, 9) < 3);
      i_RX_DONE = ($urandom_range(0, 2) == 0);
      i_RX_DATA = 8'($urandom);
      ovr_clr = ($urandom_range(0, 15) == 0);
      fifo_step();
    end
    rx_ready = 1'b0;
    i_RX_DONE = 1'b0;
    ovr_clr = 1'b0;
    fifo_step();

    // Reset mid-frame with bytes queued and a deferred divisor pending.
    do_reset();
    start_div(4);
    for (int i = 0; i < 3; i++) begin
      i_RX_DONE = 1'b1;
      i_RX_DATA = 8'(i + 1);
      step();
      i_RX_DONE = 1'b0;
      step();
    end
    check("pre_rst_count", fifo_count, 3);
    i_RX = 1'b0;
    repeat (20) step();
    check("pre_rst_busy", busy, 1);
    cfg_div = 16'd5;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    cfg_en = 1'b0;
    #1;
    check("mid_rst_tick", o_TICK, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_busy", busy, 0);
    step();
    step();
    i_RX = 1'b1;
    reset = 1'b0;
    step();
    tick_q.delete();
    repeat (20) step();
    check("rst_off_ticks", tick_q.size(), 0);
    cfg_en = 1'b1;
    en_cyc = cyc;
    tick_q.delete();
    check_ticks("default_div", en_cyc + DEF_DIV, DEF_DIV, 2);
    cfg_en = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
